ctrl_seq: RTL and testbench

Parametrised, stateful successor to the ID-stage pipeline controller. It decodes the ID-stage instruction and resolves branches in ID, as before. It also owns a kernel-mode register, NUM_IRQ maskable interrupt lines, exception/ERET sequencing, EPC/cause capture, and a redirect-flush counter. It sits between IF/ID and the ID/EX register and drives both the PC mux and the ID/EX control fields.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/irq_prio_enc.sv | 20 ++
 rtl/ctrl_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage sequencing controller: opcodes, functs,
// PC-source select, FSM states, trap causes and the ID/EX control bundle.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_COP0   = 6'h10;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ERET = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_J   = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;
  localparam logic [2:0] PC_EXC = 3'd4;
  localparam logic [2:0] PC_EPC = 3'd5;

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_KERNEL} state_t;

  // IRQ causes are the line index; illegal instruction uses NUM_IRQ (at most 8).
  localparam logic [3:0] CAUSE_NONE = 4'h0;
  localparam logic [3:0] CAUSE_MAX  = 4'h8;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;
  localparam logic [1:0] DST_K0 = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_PC   = 2'd3;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc1;
    logic       alusrc2;
    logic       extop;
    logic       luiop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [3:0] aluop;
  } ex_ctl_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled interrupt lines.
module irq_prio_enc
  import ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               vld,
  output logic [3:0]         idx
);

  always_comb begin
    vld = |req;
    idx = CAUSE_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ID-stage controller: decode, branch resolution, trap/ERET sequencing,
// redirect flush counter and the ID/EX control register.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int                 DATA_W       = 32,
  parameter int                 NUM_IRQ      = 4,
  parameter int                 FLUSH_CYCLES = 1,
  parameter logic [DATA_W-1:0]  EXC_VEC      = 32'h80000004
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [31:0]        id_inst,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic [2:0]         pc_src,
  output logic               redirect,
  output logic               flush,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_alusrc1,
  output logic               ex_alusrc2,
  output logic               ex_extop,
  output logic               ex_luiop,
  output logic [1:0]         ex_regdst,
  output logic [1:0]         ex_memtoreg,
  output logic [3:0]         ex_aluop,
  output logic               kernel,
  output logic [DATA_W-1:0]  epc,
  output logic [3:0]         cause
);

  if (NUM_IRQ < 1 || NUM_IRQ > 8) begin : g_bad_irq
    $error("ctrl_seq: NUM_IRQ must be 1..8");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush
    $error("ctrl_seq: FLUSH_CYCLES must be 1..3");
  end
  if (EXC_VEC[1:0] != 2'b00) begin : g_bad_vec
    $error("ctrl_seq: EXC_VEC must be word aligned");
  end

  localparam logic [3:0] CAUSE_ILL = 4'(NUM_IRQ);

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  state_t      state, state_n;
  logic [1:0]  flush_cnt;
  ex_ctl_t     ctl_p0, ctl_n, ctl_p1;
  logic        illegal, is_br, is_j, is_jr, is_eret, taken;
  logic        accept, trap_ill, trap_irq, irq_vld;
  logic [3:0]  irq_idx;
  logic [5:0]  op, funct;

  assign op    = id_inst[31:26];
  assign funct = id_inst[5:0];
  assign flush = (flush_cnt != 2'd0);

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req (irq & irq_mask),
    .vld (irq_vld),
    .idx (irq_idx)
  );

  // Stage p0: combinational decode of the ID instruction
  always_comb begin
    ctl_p0  = '0;
    illegal = 1'b0;
    is_br   = 1'b0;
    is_j    = 1'b0;
    is_jr   = 1'b0;
    is_eret = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctl_p0.regwrite = 1'b1;
        ctl_p0.regdst   = DST_RD;
        case (funct)
          F_SLL:          begin ctl_p0.alusrc1 = 1'b1; ctl_p0.aluop = ALU_SLL; end
          F_SRL:          begin ctl_p0.alusrc1 = 1'b1; ctl_p0.aluop = ALU_SRL; end
          F_SRA:          begin ctl_p0.alusrc1 = 1'b1; ctl_p0.aluop = ALU_SRA; end
          F_JR:           begin ctl_p0.regwrite = 1'b0; is_jr = 1'b1; end
          F_JALR:         begin ctl_p0.memtoreg = WB_LINK; is_jr = 1'b1; end
          F_ADD, F_ADDU:  ctl_p0.aluop = ALU_ADD;
          F_SUB, F_SUBU:  ctl_p0.aluop = ALU_SUB;
          F_AND:          ctl_p0.aluop = ALU_AND;
          F_OR:           ctl_p0.aluop = ALU_OR;
          F_XOR:          ctl_p0.aluop = ALU_XOR;
          F_NOR:          ctl_p0.aluop = ALU_NOR;
          F_SLT:          ctl_p0.aluop = ALU_SLT;
          F_SLTU:         ctl_p0.aluop = ALU_SLTU;
          default:        illegal = 1'b1;
        endcase
        // The canonical nop is sll $0,$0,0 and must not write
        if (id_inst == 32'h0) ctl_p0.regwrite = 1'b0;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_br = 1'b1;
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_j = 1'b1;
        ctl_p0.regwrite = 1'b1;
        ctl_p0.regdst   = DST_RA;
        ctl_p0.memtoreg = WB_LINK;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI: begin
        ctl_p0.regwrite = 1'b1;
        ctl_p0.alusrc2  = 1'b1;
        ctl_p0.extop    = (op != OP_ANDI);
        ctl_p0.aluop    = (op == OP_SLTI)  ? ALU_SLT  :
                          (op == OP_SLTIU) ? ALU_SLTU :
                          (op == OP_ANDI)  ? ALU_AND  : ALU_ADD;
      end
      OP_LUI: begin
        ctl_p0.regwrite = 1'b1;
        ctl_p0.alusrc2  = 1'b1;
        ctl_p0.luiop    = 1'b1;
        ctl_p0.aluop    = ALU_LUI;
      end
      OP_LW: begin
        ctl_p0.regwrite = 1'b1;
        ctl_p0.memread  = 1'b1;
        ctl_p0.alusrc2  = 1'b1;
        ctl_p0.extop    = 1'b1;
        ctl_p0.memtoreg = WB_MEM;
      end
      OP_SW: begin
        ctl_p0.memwrite = 1'b1;
        ctl_p0.alusrc2  = 1'b1;
        ctl_p0.extop    = 1'b1;
      end
      OP_COP0: begin
        if (funct == F_ERET) is_eret = 1'b1;
        else                 illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OP_BEQ:    taken = (rs_val == rt_val);
      OP_BNE:    taken = (rs_val != rt_val);
      OP_BLEZ:   taken = rs_val[DATA_W-1] || (rs_val == '0);
      OP_BGTZ:   taken = !rs_val[DATA_W-1] && (rs_val != '0);
      OP_REGIMM: taken = id_inst[16] ? !rs_val[DATA_W-1] : rs_val[DATA_W-1];
      default:   taken = 1'b0;
    endcase
  end

  assign accept = !reset && id_valid && !flush &&
                  (state == ST_RUN || state == ST_KERNEL);

  // Sequencing: trap/ERET decisions, PC select and next EX controls
  always_comb begin
    state_n  = state;
    pc_src   = PC_SEQ;
    ctl_n    = '0;
    trap_ill = 1'b0;
    trap_irq = 1'b0;
    if (!reset) begin
      if (state == ST_TRAP) begin
        state_n        = ST_KERNEL;
        pc_src         = PC_EXC;
        ctl_n.regwrite = 1'b1;
        ctl_n.regdst   = DST_K0;
        ctl_n.memtoreg = WB_PC;
      end else if (accept) begin
        if (state == ST_RUN && (illegal || is_eret)) begin
          trap_ill = 1'b1;
          state_n  = ST_TRAP;
        end else if (state == ST_RUN && irq_vld) begin
          trap_irq = 1'b1;
          state_n  = ST_TRAP;
        end else if (!illegal) begin
          ctl_n = ctl_p0;
          if (is_eret) begin
            pc_src  = PC_EPC;
            state_n = ST_RUN;
          end else if (is_jr)          pc_src = PC_JR;
          else if (is_j)               pc_src = PC_J;
          else if (is_br && taken)     pc_src = PC_BR;
        end
      end
    end
  end

  assign redirect = (pc_src != PC_SEQ);
  assign kernel   = (state == ST_KERNEL);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset)         flush_cnt <= 2'd0;
    else if (redirect) flush_cnt <= 2'(FLUSH_CYCLES);
    else               flush_cnt <= sat_dec(flush_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epc   <= '0;
      cause <= CAUSE_NONE;
    end else if (trap_ill) begin
      epc   <= id_pc + DATA_W'(4);
      cause <= CAUSE_ILL;
    end else if (trap_irq) begin
      epc   <= id_pc;
      cause <= irq_idx;
    end
  end

  // Stage p1: ID/EX control register
  always_ff @(posedge clk) begin
    if (reset) ctl_p1 <= '0;
    else       ctl_p1 <= ctl_n;
  end

  assign ex_regwrite = ctl_p1.regwrite;
  assign ex_memread  = ctl_p1.memread;
  assign ex_memwrite = ctl_p1.memwrite;
  assign ex_alusrc1  = ctl_p1.alusrc1;
  assign ex_alusrc2  = ctl_p1.alusrc2;
  assign ex_extop    = ctl_p1.extop;
  assign ex_luiop    = ctl_p1.luiop;
  assign ex_regdst   = ctl_p1.regdst;
  assign ex_memtoreg = ctl_p1.memtoreg;
  assign ex_aluop    = ctl_p1.aluop;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with FLUSH_CYCLES=2 and four interrupt lines.
module tb_ctrl_seq;

  localparam logic [31:0] I_BEQ  = 32'h1000_0003;
  localparam logic [31:0] I_BNE  = 32'h1400_0003;
  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;
  localparam logic [31:0] I_ERET = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc, rs_val, rt_val;
  logic [3:0]  irq, irq_mask;
  logic [2:0]  pc_src;
  logic        redirect, flush;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_alusrc1, ex_alusrc2;
  logic        ex_extop, ex_luiop;
  logic [1:0]  ex_regdst, ex_memtoreg;
  logic [3:0]  ex_aluop;
  logic        kernel;
  logic [31:0] epc;
  logic [3:0]  cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.DATA_W(32), .NUM_IRQ(4), .FLUSH_CYCLES(2), .EXC_VEC(32'h80000004)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .rs_val(rs_val), .rt_val(rt_val), .irq(irq), .irq_mask(irq_mask),
    .pc_src(pc_src), .redirect(redirect), .flush(flush),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_extop(ex_extop),
    .ex_luiop(ex_luiop), .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg),
    .ex_aluop(ex_aluop), .kernel(kernel), .epc(epc), .cause(cause)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    id_valid = v;
    id_inst  = inst;
    id_pc    = pc;
    rs_val   = rs;
    rt_val   = rt;
    #1;
  endtask

  // Drains the trap flush, issues ERET and drains again, leaving RUN with flush=0.
  task automatic return_to_user();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    drive(1'b1, I_ERET, 32'h9000, 32'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL rst_pc_src got %0d want 0", pc_src); end
      tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL rst_redirect got %b want 0", redirect); end
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_flush got %b want 0", flush); end
      tests++; if (kernel !== 1'b0) begin fails++; $display("FAIL rst_kernel got %b want 0", kernel); end
      tests++; if ({ex_regwrite, ex_regdst, ex_aluop} !== 7'd0) begin fails++; $display("FAIL rst_ex got %b want 0", {ex_regwrite, ex_regdst, ex_aluop}); end
      tests++; if (epc !== 32'h0 || cause !== 4'h0) begin fails++; $display("FAIL rst_epc_cause got %h/%0d want 0/0", epc, cause); end
    end
    reset = 1'b0;
    drive(1'b1, I_ADD, 32'h10, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL rel_pc_src got %0d want 0", pc_src); end
    step();
    tests++; if (ex_regwrite !== 1'b1 || ex_regdst !== 2'd1) begin fails++; $display("FAIL rel_accept got rw=%b dst=%0d want 1/1", ex_regwrite, ex_regdst); end
  endtask

  task automatic test_branch();
    drive(1'b1, I_BEQ, 32'h40, 32'd5, 32'd5);
    tests++; if (pc_src !== 3'd1 || redirect !== 1'b1) begin fails++; $display("FAIL beq_pc_src got %0d/%b want 1/1", pc_src, redirect); end
    step();
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL beq_flush1 got %b want 1", flush); end
    tests++; if (ex_regwrite !== 1'b0) begin fails++; $display("FAIL beq_regwrite got %b want 0", ex_regwrite); end
    drive(1'b1, I_ADD, 32'h44, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL flush_pc_src got %0d want 0", pc_src); end
    step();
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL beq_flush2 got %b want 1", flush); end
    tests++; if (ex_regwrite !== 1'b0) begin fails++; $display("FAIL flush_squash1 got %b want 0", ex_regwrite); end
    step();
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL beq_flush_end got %b want 0", flush); end
    tests++; if (ex_regwrite !== 1'b0) begin fails++; $display("FAIL flush_squash2 got %b want 0", ex_regwrite); end
    step();
    tests++; if (ex_regwrite !== 1'b1) begin fails++; $display("FAIL post_flush_add got %b want 1", ex_regwrite); end
    drive(1'b1, I_BNE, 32'h48, 32'd5, 32'd5);
    tests++; if (pc_src !== 3'd0 || redirect !== 1'b0) begin fails++; $display("FAIL bne_nt got %0d/%b want 0/0", pc_src, redirect); end
    step();
    drive(1'b1, I_LW, 32'h4c, 32'h0, 32'h0);
    step();
    tests++; if ({ex_regwrite, ex_memread, ex_alusrc2, ex_extop, ex_memtoreg} !== 6'b111101) begin fails++; $display("FAIL lw_ctl got %b want 111101", {ex_regwrite, ex_memread, ex_alusrc2, ex_extop, ex_memtoreg}); end
    drive(1'b1, I_J, 32'h50, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd2) begin fails++; $display("FAIL j_pc_src got %0d want 2", pc_src); end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL j_flush_end got %b want 0", flush); end
  endtask

  task automatic test_irq();
    irq = 4'b0100; irq_mask = 4'b1011;
    drive(1'b1, I_ADD, 32'hF0, 32'h0, 32'h0);
    step();
    tests++; if (ex_regwrite !== 1'b1 || pc_src !== 3'd0) begin fails++; $display("FAIL masked_irq got rw=%b pc=%0d want 1/0", ex_regwrite, pc_src); end
    irq = 4'b0110; irq_mask = 4'b1111;
    drive(1'b1, I_ADD, 32'h100, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL irq_dec_pc_src got %0d want 0", pc_src); end
    step();
    tests++; if (epc !== 32'h100 || cause !== 4'd1) begin fails++; $display("FAIL irq_epc_cause got %h/%0d want 100/1", epc, cause); end
    tests++; if (ex_regwrite !== 1'b0) begin fails++; $display("FAIL irq_bubble got %b want 0", ex_regwrite); end
    tests++; if (pc_src !== 3'd4 || redirect !== 1'b1 || kernel !== 1'b0) begin fails++; $display("FAIL trap_cycle got %0d/%b/%b want 4/1/0", pc_src, redirect, kernel); end
    step();
    tests++; if (kernel !== 1'b1) begin fails++; $display("FAIL irq_kernel got %b want 1", kernel); end
    tests++; if ({ex_regwrite, ex_regdst, ex_memtoreg} !== 5'b11111) begin fails++; $display("FAIL trap_ex got %b want 11111", {ex_regwrite, ex_regdst, ex_memtoreg}); end
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL trap_flush got %b want 1", flush); end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
  endtask

  task automatic test_kernel_eret();
    drive(1'b1, I_ADD, 32'h108, 32'h0, 32'h0);
    step();
    tests++; if (kernel !== 1'b1 || ex_regwrite !== 1'b1 || epc !== 32'h100) begin fails++; $display("FAIL kern_irq_ignored got k=%b rw=%b epc=%h want 1/1/100", kernel, ex_regwrite, epc); end
    drive(1'b1, I_ILL, 32'h10C, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL kern_ill_pc_src got %0d want 0", pc_src); end
    step();
    tests++; if (kernel !== 1'b1 || ex_regwrite !== 1'b0 || cause !== 4'd1) begin fails++; $display("FAIL kern_ill_bubble got k=%b rw=%b c=%0d want 1/0/1", kernel, ex_regwrite, cause); end
    drive(1'b1, I_ERET, 32'h110, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd5 || redirect !== 1'b1) begin fails++; $display("FAIL eret_pc_src got %0d/%b want 5/1", pc_src, redirect); end
    step();
    tests++; if (kernel !== 1'b0 || flush !== 1'b1) begin fails++; $display("FAIL eret_run got k=%b f=%b want 0/1", kernel, flush); end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    drive(1'b1, I_ADD, 32'h300, 32'h0, 32'h0);
    step();
    tests++; if (epc !== 32'h300 || cause !== 4'd1 || pc_src !== 3'd4) begin fails++; $display("FAIL pend_irq_trap got %h/%0d/%0d want 300/1/4", epc, cause, pc_src); end
    irq = 4'b0000;
    step();
    return_to_user();
    tests++; if (kernel !== 1'b0) begin fails++; $display("FAIL back_to_run got %b want 0", kernel); end
  endtask

  task automatic test_illegal_vs_irq();
    irq = 4'b0001;
    drive(1'b1, I_ILL, 32'h200, 32'h0, 32'h0);
    step();
    tests++; if (cause !== 4'd4 || epc !== 32'h204) begin fails++; $display("FAIL ill_prio got %0d/%h want 4/204", cause, epc); end
    tests++; if (pc_src !== 3'd4) begin fails++; $display("FAIL ill_trap got %0d want 4", pc_src); end
    irq = 4'b0000;
    step();
    return_to_user();
  endtask

  task automatic test_reset_in_trap();
    drive(1'b1, I_ERET, 32'h400, 32'h0, 32'h0);
    tests++; if (pc_src !== 3'd0) begin fails++; $display("FAIL eret_run_pc_src got %0d want 0", pc_src); end
    step();
    tests++; if (cause !== 4'd4 || epc !== 32'h404 || pc_src !== 3'd4) begin fails++; $display("FAIL eret_in_run got %0d/%h/%0d want 4/404/4", cause, epc, pc_src); end
    reset = 1'b1;
    #1;
    tests++; if (pc_src !== 3'd0 || redirect !== 1'b0) begin fails++; $display("FAIL rst_trap_pc got %0d/%b want 0/0", pc_src, redirect); end
    step();
    tests++; if (kernel !== 1'b0 || epc !== 32'h0 || cause !== 4'd0) begin fails++; $display("FAIL rst_trap_state got %b/%h/%0d want 0/0/0", kernel, epc, cause); end
    tests++; if (flush !== 1'b0 || ex_regwrite !== 1'b0) begin fails++; $display("FAIL rst_trap_ctl got %b/%b want 0/0", flush, ex_regwrite); end
    step();
    tests++; if (kernel !== 1'b0) begin fails++; $display("FAIL rst_hold_kernel got %b want 0", kernel); end
    reset = 1'b0;
    irq = 4'b1000;
    drive(1'b1, I_ADD, 32'h500, 32'h0, 32'h0);
    step();
    tests++; if (cause !== 4'd3 || epc !== 32'h500) begin fails++; $display("FAIL run_after_rst got %0d/%h want 3/500", cause, epc); end
    irq = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    irq = 4'b0000;
    irq_mask = 4'b1111;
    drive(1'b1, I_BEQ, 32'h0, 32'd5, 32'd5);
    test_reset();
    test_branch();
    test_irq();
    test_kernel_eret();
    test_illegal_vs_irq();
    test_reset_in_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
